// File: rtl/imem_load_ctrl_pkg.sv
// Shared constants and state encoding for the instruction-memory download controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package imem_load_ctrl_pkg;

  localparam int IMEM_DEPTH       = 32;
  localparam int IMEM_ADDR_W      = 5;
  localparam int IMEM_TIMEOUT_CYC = 260300;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/imem_load_ctrl_rise_det.sv
// Single-flop rising-edge detector; the flop resets to 1 so a level held high through reset is not an edge.
// Latency: rise is combinational in the cycle the input first reads 1.
// Backpressure: none.
//
// Ports:
//   Clk, Reset : clock, asynchronous active-high reset
//   d          : level input
//   rise       : high for the one cycle where d=1 and the previous sample was 0
module rise_det (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) d_q <= 1'b1;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/imem_load_ctrl.sv
// Program-download sequencer: holds the CPU and streams UART bytes into consecutive instruction-memory addresses.
// Latency: Load rise -> Cpu_hold one cycle later; Rx_valid -> registered Mem_we pulse one cycle later.
// Backpressure: none; the UART cannot be stalled, bytes outside a session or past a full memory are dropped.
//
// Ports:
//   Clk, Reset          : clock, asynchronous active-high reset
//   Load                : session request level (rising edge starts a session)
//   Rx_valid/Rx_data    : received byte strobe and data
//   Rx_fe               : framing-error strobe, aborts the session into ERR
//   PC                  : CPU fetch address, routed to Mem_addr outside a session
//   Mem_we/Mem_addr/Mem_wdata : instruction memory write/read port
//   Cpu_hold, Cpu_rst   : CPU stall level and restart pulse
//   Load_done, Err      : session-complete pulse, sticky framing-error flag
//   Byte_count          : bytes written in the current or last session
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int DEPTH       = IMEM_DEPTH,
  parameter int ADDR_W      = IMEM_ADDR_W,
  parameter int TIMEOUT_CYC = IMEM_TIMEOUT_CYC
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Load,
  input  logic              Rx_valid,
  input  logic [7:0]        Rx_data,
  input  logic              Rx_fe,
  input  logic [ADDR_W-1:0] PC,
  output logic              Mem_we,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic [7:0]        Mem_wdata,
  output logic              Cpu_hold,
  output logic              Cpu_rst,
  output logic              Load_done,
  output logic              Err,
  output logic [ADDR_W:0]   Byte_count
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  // The counter reads k-1 in the k-th idle cycle after a byte, so matching
  // TIMEOUT_CYC-2 here lands DONE exactly TIMEOUT_CYC cycles after that byte.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 2);

  state_t              state_q, state_d;
  logic                load_rise;
  logic                start;
  logic                accept;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W:0]     cnt_q;
  logic [TMO_W-1:0]    tmo_q;
  logic                we_q;
  logic [ADDR_W-1:0]   wa_q;
  logic [7:0]          wd_q;
  logic                err_q;

  rise_det u_load_rise (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (Load),
    .rise  (load_rise)
  );

  assign start  = load_rise && (state_q == IDLE || state_q == ERR);
  // A framing error drops the byte that arrives with it; a full memory drops extras.
  assign accept = (state_q == LOAD) && Rx_valid && !Rx_fe && (cnt_q != DEPTH_CNT);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    Cpu_hold  = 1'b0;
    Cpu_rst   = 1'b0;
    Load_done = 1'b0;
    Mem_addr  = PC;
    case (state_q)
      IDLE: begin
        if (load_rise) state_d = LOAD;
      end
      LOAD: begin
        Cpu_hold = 1'b1;
        Mem_addr = ptr_q;
        if (Rx_fe)
          state_d = ERR;
        else if (cnt_q == DEPTH_CNT || !Load || (!Rx_valid && tmo_q == TMO_LAST))
          state_d = DONE;
      end
      DONE: begin
        Cpu_hold  = 1'b1;
        Cpu_rst   = 1'b1;
        Load_done = 1'b1;
        state_d   = IDLE;
      end
      ERR: begin
        Cpu_hold = 1'b1;
        if (load_rise) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
    // The final byte of a session is written in the DONE cycle, so the
    // registered write address overrides whatever the state would drive.
    if (we_q) Mem_addr = wa_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      we_q  <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      we_q <= accept;
      if (accept) begin
        wa_q <= ptr_q;
        wd_q <= Rx_data;
      end
      if (start) begin
        ptr_q <= '0;
        cnt_q <= '0;
        tmo_q <= '0;
        err_q <= 1'b0;
      end else if (state_q == LOAD) begin
        if (accept) begin
          ptr_q <= ptr_q + ADDR_W'(1);
          cnt_q <= cnt_q + (ADDR_W+1)'(1);
        end
        if (Rx_valid) tmo_q <= '0;
        else          tmo_q <= tmo_q + TMO_W'(1);
        if (Rx_fe) err_q <= 1'b1;
      end
    end
  end

  assign Mem_we     = we_q;
  assign Mem_wdata  = wd_q;
  assign Err        = err_q;
  assign Byte_count = cnt_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;

  localparam int T = 40;

  logic       Clk;
  logic       Reset;
  logic       Load;
  logic       Rx_valid;
  logic [7:0] Rx_data;
  logic       Rx_fe;
  logic [4:0] PC;
  logic       Mem_we;
  logic [4:0] Mem_addr;
  logic [7:0] Mem_wdata;
  logic       Cpu_hold;
  logic       Cpu_rst;
  logic       Load_done;
  logic       Err;
  logic [5:0] Byte_count;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks   = 0;
  int  failures = 0;
  int  done_cnt = 0;
  int  rst_cnt  = 0;

  imem_load_ctrl #(.DEPTH(32), .ADDR_W(5), .TIMEOUT_CYC(T)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Load       (Load),
    .Rx_valid   (Rx_valid),
    .Rx_data    (Rx_data),
    .Rx_fe      (Rx_fe),
    .PC         (PC),
    .Mem_we     (Mem_we),
    .Mem_addr   (Mem_addr),
    .Mem_wdata  (Mem_wdata),
    .Cpu_hold   (Cpu_hold),
    .Cpu_rst    (Cpu_rst),
    .Load_done  (Load_done),
    .Err        (Err),
    .Byte_count (Byte_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit expect_wr, input logic [4:0] a);
    Rx_valid = 1'b1;
    Rx_data  = d;
    if (expect_wr) sb.push_back('{addr: a, data: d});
    tick();
    Rx_valid = 1'b0;
  endtask

  // Write monitor: every Mem_we pulse must match the oldest expected write.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (Load_done) done_cnt++;
      if (Cpu_rst)   rst_cnt++;
      if (Mem_we) begin
        checks++;
        assert (sb.size() != 0) else begin
          failures++;
          $error("FAIL wr_unexpected observed=addr %0h data %0h expected=no write", Mem_addr, Mem_wdata);
        end
        if (sb.size() != 0) begin
          wr_t e;
          e = sb.pop_front();
          chk("wr_addr", 32'(Mem_addr), 32'(e.addr));
          chk("wr_data", 32'(Mem_wdata), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    Reset = 1'b1; Load = 1'b0; Rx_valid = 1'b0; Rx_data = 8'h00; Rx_fe = 1'b0; PC = 5'h0A;
    tick(); tick();
    // reset state
    chk("rst_we",    32'(Mem_we),     32'(0));
    chk("rst_wdata", 32'(Mem_wdata),  32'(0));
    chk("rst_hold",  32'(Cpu_hold),   32'(0));
    chk("rst_cpurst",32'(Cpu_rst),    32'(0));
    chk("rst_done",  32'(Load_done),  32'(0));
    chk("rst_err",   32'(Err),        32'(0));
    chk("rst_cnt",   32'(Byte_count), 32'(0));
    chk("rst_addr",  32'(Mem_addr),   32'(5'h0A));
    Reset = 1'b0;
    tick(); tick();

    // full 32-byte load
    Load = 1'b1;
    tick();
    chk("t1_hold_on", 32'(Cpu_hold), 32'(1));
    chk("t1_cnt0",    32'(Byte_count), 32'(0));
    for (int i = 0; i < 32; i++) send(8'(i), 1'b1, 5'(i));
    chk("t1_cnt32",   32'(Byte_count), 32'(32));
    chk("t1_hold_wr", 32'(Cpu_hold), 32'(1));
    chk("t1_nodone",  32'(Load_done), 32'(0));
    tick();
    chk("t1_done",    32'(Load_done), 32'(1));
    chk("t1_cpurst",  32'(Cpu_rst), 32'(1));
    chk("t1_hold_dn", 32'(Cpu_hold), 32'(1));
    tick();
    chk("t1_hold_off",32'(Cpu_hold), 32'(0));
    chk("t1_done_off",32'(Load_done), 32'(0));
    chk("t1_addr_pc", 32'(Mem_addr), 32'(5'h0A));
    send(8'h99, 1'b0, 5'd0);           // Load still high: no new session, byte ignored
    chk("t1_hold_idle",32'(Cpu_hold), 32'(0));
    Load = 1'b0;
    tick();
    chk("t1_sb_empty", 32'(sb.size()), 32'(0));
    chk("t1_done_n",   32'(done_cnt), 32'(1));
    chk("t1_cpurst_n", 32'(rst_cnt), 32'(1));

    // partial load: 5th byte arrives in the cycle Load falls
    PC = 5'h13;
    Load = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send(8'h40 + 8'(i), 1'b1, 5'(i));
    Load = 1'b0;
    send(8'h44, 1'b1, 5'd4);
    chk("t2_done",    32'(Load_done), 32'(1));
    chk("t2_cnt5",    32'(Byte_count), 32'(5));
    tick();
    chk("t2_hold_off",32'(Cpu_hold), 32'(0));
    chk("t2_addr_pc", 32'(Mem_addr), 32'(5'h13));
    send(8'h77, 1'b0, 5'd0);           // byte in IDLE is ignored
    tick(); tick();
    chk("t2_cnt_keep",32'(Byte_count), 32'(5));
    chk("t2_sb_empty",32'(sb.size()), 32'(0));

    // idle timeout after 3 bytes
    Load = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) send(8'hC0 + 8'(i), 1'b1, 5'(i));
    k = 1;
    while (!Load_done && k < 3 * T) begin
      tick();
      k++;
    end
    chk("t3_tmo_cycles", 32'(k), 32'(T));
    chk("t3_cnt3",       32'(Byte_count), 32'(3));
    tick();
    chk("t3_hold_off",   32'(Cpu_hold), 32'(0));
    Load = 1'b0;
    tick();
    chk("t3_sb_empty",   32'(sb.size()), 32'(0));

    // framing error together with the 5th byte
    PC = 5'h11;
    Load = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b1, 5'(i));
    Rx_fe = 1'b1;
    send(8'hAA, 1'b0, 5'd0);
    Rx_fe = 1'b0;
    chk("t4_err",     32'(Err), 32'(1));
    chk("t4_hold",    32'(Cpu_hold), 32'(1));
    chk("t4_we",      32'(Mem_we), 32'(0));
    chk("t4_cnt4",    32'(Byte_count), 32'(4));
    chk("t4_addr_pc", 32'(Mem_addr), 32'(5'h11));
    send(8'h55, 1'b0, 5'd0);           // no writes in ERR
    Load = 1'b0;
    tick(); tick();
    chk("t4_err_stk", 32'(Err), 32'(1));
    chk("t4_hold_stk",32'(Cpu_hold), 32'(1));
    chk("t4_nodone",  32'(done_cnt), 32'(3));
    Load = 1'b1;
    tick();
    chk("t4_err_clr", 32'(Err), 32'(0));
    chk("t4_cnt_clr", 32'(Byte_count), 32'(0));
    send(8'h5A, 1'b1, 5'd0);
    Load = 1'b0;
    tick(); tick();
    chk("t4_cnt1",    32'(Byte_count), 32'(1));
    chk("t4_sb_empty",32'(sb.size()), 32'(0));

    // reset lands between Rx_valid and its write
    Load = 1'b1;
    tick();
    Rx_valid = 1'b1; Rx_data = 8'h33;
    tick();
    Reset = 1'b1; Rx_valid = 1'b0;
    #1;
    chk("t5_we",     32'(Mem_we), 32'(0));
    chk("t5_hold",   32'(Cpu_hold), 32'(0));
    chk("t5_cnt",    32'(Byte_count), 32'(0));
    chk("t5_wdata",  32'(Mem_wdata), 32'(0));
    chk("t5_err",    32'(Err), 32'(0));
    chk("t5_addr",   32'(Mem_addr), 32'(5'h11));
    PC = 5'h07;
    #1;
    chk("t5_addr_pc",32'(Mem_addr), 32'(5'h07));
    tick();
    Reset = 1'b0;
    tick(); tick();
    // Load held high through reset: no session
    chk("t6_no_sess",32'(Cpu_hold), 32'(0));
    send(8'h66, 1'b0, 5'd0);
    chk("t6_cnt",    32'(Byte_count), 32'(0));
    Load = 1'b0;
    tick();
    Load = 1'b1;
    tick();
    chk("t6_sess",   32'(Cpu_hold), 32'(1));
    Load = 1'b0;
    tick(); tick();
    chk("t6_hold_off",32'(Cpu_hold), 32'(0));
    chk("t6_sb_empty",32'(sb.size()), 32'(0));
    chk("t6_done_n",  32'(done_cnt), 32'(5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Sequencing controller for program download. It sits between the UART receive path and the 32×8 instruction memory. On a rising edge of `Load` it holds the CPU, clears its counters and writes each received byte to consecutive instruction-memory addresses. It ends the session on full memory, `Load` release, idle timeout or framing error. Outside a load session it gives the memory read port to the CPU fetch address `PC`.

## Interface
Parameters:
- `DEPTH`, 32, instruction memory depth in bytes.
- `ADDR_W`, 5, address width (log2 `DEPTH`).
- `TIMEOUT_CYC`, 260300, idle `Clk` cycles with no byte that end a session early.

Ports:
- `Clk`  in  1  system clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `Load`  in  1  level request from the switch; its rising edge starts a session.
- `Rx_valid`  in  1  one-cycle pulse: `Rx_data` holds a complete byte.
- `Rx_data`  in  8  received byte.
- `Rx_fe`  in  1  one-cycle framing-error pulse from the receiver.
- `PC`  in  `ADDR_W`  CPU fetch address.
- `Mem_we`  out  1  instruction memory write enable.
- `Mem_addr`  out  `ADDR_W`  memory address (write or fetch).
- `Mem_wdata`  out  8  memory write data.
- `Cpu_hold`  out  1  stalls the CPU while high.
- `Cpu_rst`  out  1  one-cycle pulse that restarts the CPU at PC=0.
- `Load_done`  out  1  one-cycle pulse at successful session end.
- `Err`  out  1  sticky framing-error flag.
- `Byte_count`  out  `ADDR_W`+1  bytes written in the current or last session.

## Operation
- States: `IDLE`, `LOAD`, `DONE`, `ERR`.
- `IDLE`:
  - `Cpu_hold`=0; `Mem_addr`=`PC`.
  - On a `Load` rise: go to `LOAD`; clear `Byte_count`, write pointer, timeout counter and `Err`.
- `LOAD`:
  - `Cpu_hold`=1; `Mem_addr`=write pointer whenever `Mem_we`=1, else the write pointer is still driven.
  - Each `Rx_valid` writes `Rx_data` at the pointer, increments pointer and count, and clears the timeout counter.
  - The timeout counter increments every cycle without `Rx_valid`.
- Exits from `LOAD`:
  - Count reaches `DEPTH` → `DONE`.
  - `Load`=0 → `DONE`. Partial load: unwritten locations are left unchanged.
  - Timeout counter = `TIMEOUT_CYC`−1 → `DONE`.
  - `Rx_fe` → `ERR`.
- `DONE`: lasts one cycle. Pulses `Load_done` and `Cpu_rst`, holds `Cpu_hold`=1, then returns to `IDLE`.
- `ERR`:
  - `Err`=1 and `Cpu_hold`=1; `Mem_addr`=`PC`; no writes.
  - Leaves only on a new `Load` rise, which re-enters `LOAD`.
- Bytes arriving outside `LOAD` are ignored.
- `Byte_count` saturates at `DEPTH`. The write pointer wraps at `DEPTH` but is never used past it.
- `Load` edge flop resets to 1, so `Load` held high through reset does not start a session.

## Timing
- Reset values: state `IDLE`, `Mem_we`=0, `Mem_wdata`=0, `Cpu_hold`=0, `Cpu_rst`=0, `Load_done`=0, `Err`=0, `Byte_count`=0, pointer 0.
- `Load` rise at cycle n → `LOAD` and `Cpu_hold`=1 at n+1.
- `Rx_valid` at cycle n → `Mem_we`=1 at n+1, with the registered address and data. `Byte_count` updates at n+1.
- `Mem_we` is a registered 1-cycle pulse. Back-to-back `Rx_valid` gives back-to-back writes.
- 32nd write at cycle n+1 → `DONE` at n+2, with `Load_done`/`Cpu_rst` high for that cycle → `IDLE` at n+3.
- `Rx_valid` and `Rx_fe` in the same cycle: `Rx_fe` wins, the byte is dropped, go to `ERR`.
- `Rx_valid` in the same cycle `Load` falls: the byte is written, then `DONE`.
- `Reset` mid-session: immediate return to `IDLE`. A pending write is cancelled (`Mem_we`=0 asynchronously).

## Structure
- Shared package:
  - state enum (`IDLE`/`LOAD`/`DONE`/`ERR`, 2 bits);
  - `IMEM_DEPTH`=32;
  - `IMEM_ADDR_W`=5;
  - default `TIMEOUT_CYC`.
- One sub-module, `rise_det`: a single-flop rising-edge detector on `Load`, with reset value 1.
- Memory and UART receiver stay outside this block.

## Test plan
- Load rise, 32 bytes 0x00..0x1F → 32 `Mem_we` pulses at addresses 0..31 with matching data. `Load_done` and `Cpu_rst` pulse once; `Byte_count`=32; `Cpu_hold` falls.
- Load rise, 5 bytes, then `Load`=0 → 5 writes; `Byte_count`=5; `DONE`; address 5 is not written.
- Load rise, 3 bytes, then `TIMEOUT_CYC` idle cycles → `DONE` exactly `TIMEOUT_CYC` cycles after the last `Rx_valid`.
- `Rx_fe` together with `Rx_valid`(0xAA) at byte 4 → no write of 0xAA; `Err`=1; `Cpu_hold` stays 1. A new `Load` rise clears `Err` and count.
- `Reset` pulse between `Rx_valid` and the write → no `Mem_we`; all outputs at reset values; `Mem_addr` follows `PC`.
- `Load` high at reset release → no session starts until `Load` falls and rises again.
